// File: rtl/oa_tile_accumulator.sv
// OA tile accumulator: folds bias plus a sequence of partial-sum beats into ROWS_MAX x SIZE
// saturating accumulators, then drains the finished rows over a valid/ready stream.

module oa_acc_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  ovf
);
  logic [DATA_WIDTH:0] wide;

  assign wide = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};

  // Top two bits of the sign-extended sum disagree exactly when the result left the signed range.
  always_comb begin
    ovf = wide[DATA_WIDTH] ^ wide[DATA_WIDTH-1];
    if (!ovf)                sum = wide[DATA_WIDTH-1:0];
    else if (wide[DATA_WIDTH]) sum = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                     sum = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end
endmodule

module oa_tile_accumulator #(
  parameter int SIZE       = 16,
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 32,
  parameter int ROWS_MAX   = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             init_cfg,
  input  logic [REG_WIDTH-1:0]             n_rows,
  input  logic [SIZE-1:0][DATA_WIDTH-1:0]  bias_in,
  input  logic                             tile_calc_start,
  input  logic                             partial_sum_calc_over,
  input  logic                             tile_calc_over,
  input  logic                             psum_valid,
  output logic                             psum_ready,
  input  logic [SIZE-1:0][DATA_WIDTH-1:0]  psum_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SIZE-1:0][DATA_WIDTH-1:0]  out_data,
  output logic                             out_last,
  output logic                             ovf_flag,
  output logic                             err_flag
);
  localparam int CNT_W = $clog2(ROWS_MAX + 1);
  localparam int IDX_W = (ROWS_MAX > 1) ? $clog2(ROWS_MAX) : 1;

  typedef logic [SIZE-1:0][DATA_WIDTH-1:0] row_t;
  typedef enum logic [1:0] {IDLE, BIAS_WAIT, ACCUM, DRAIN} state_t;

  state_t           state, state_nx;
  row_t             acc [ROWS_MAX];
  row_t             bias_reg, lane_a, lane_sum;
  logic [SIZE-1:0]  lane_ovf;
  logic [CNT_W-1:0] cfg_rows, cfg_clamp, row_cnt, drain_cnt;
  logic [IDX_W-1:0] row_idx, drain_idx;
  logic             wait_cnt, first_ps;

  logic init_d, start_d, psov_d, tov_d;
  logic init_p, start_p, psov_p, tov_p;
  logic acc_we, drop, ps_end, drain_go, hs, drain_end, drain_last;

  // ---- control edge detection ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_d  <= 1'b0;
      start_d <= 1'b0;
      psov_d  <= 1'b0;
      tov_d   <= 1'b0;
    end else begin
      init_d  <= init_cfg;
      start_d <= tile_calc_start;
      psov_d  <= partial_sum_calc_over;
      tov_d   <= tile_calc_over;
    end
  end

  assign init_p  = init_cfg & ~init_d;
  assign start_p = tile_calc_start & ~start_d;
  assign psov_p  = partial_sum_calc_over & ~psov_d;
  assign tov_p   = tile_calc_over & ~tov_d;

  always_comb begin
    if (n_rows == '0)                         cfg_clamp = CNT_W'(1);
    else if (n_rows > REG_WIDTH'(ROWS_MAX))   cfg_clamp = CNT_W'(ROWS_MAX);
    else                                      cfg_clamp = n_rows[CNT_W-1:0];
  end

  // row_cnt may equal ROWS_MAX; the wrapped index is only read then, never written.
  assign row_idx    = row_cnt[IDX_W-1:0];
  assign drain_idx  = drain_cnt[IDX_W-1:0];
  assign drain_last = (drain_cnt == cfg_rows - CNT_W'(1));

  // ---- per-lane saturating adders ----
  assign lane_a = first_ps ? bias_reg : acc[row_idx];

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    oa_acc_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .a   (lane_a[i]),
      .b   (psum_in[i]),
      .sum (lane_sum[i]),
      .ovf (lane_ovf[i])
    );
  end

  // ---- FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    psum_ready = 1'b0;
    acc_we     = 1'b0;
    drop       = 1'b0;
    ps_end     = 1'b0;
    drain_go   = 1'b0;
    hs         = 1'b0;
    drain_end  = 1'b0;
    case (state)
      IDLE: begin
        if (tov_p) begin
          drain_go = 1'b1;
          state_nx = DRAIN;
        end else if (start_p) begin
          state_nx = BIAS_WAIT;
        end
      end
      BIAS_WAIT: begin
        if (wait_cnt) state_nx = ACCUM;
      end
      ACCUM: begin
        psum_ready = 1'b1;
        if (psum_valid) begin
          if (row_cnt == cfg_rows) drop   = 1'b1;
          else                     acc_we = 1'b1;
        end
        // a same-cycle beat is taken first; tile over wins the next state
        if (psov_p) begin
          ps_end   = 1'b1;
          state_nx = IDLE;
        end
        if (tov_p) begin
          drain_go = 1'b1;
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          hs = 1'b1;
          if (drain_last) begin
            drain_end = 1'b1;
            state_nx  = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---- datapath ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS_MAX; r++) acc[r] <= '0;
      bias_reg  <= '0;
      cfg_rows  <= CNT_W'(1);
      row_cnt   <= '0;
      drain_cnt <= '0;
      wait_cnt  <= 1'b0;
      first_ps  <= 1'b1;
      ovf_flag  <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      if (state == IDLE && state_nx == BIAS_WAIT) begin
        row_cnt  <= '0;
        wait_cnt <= 1'b0;
      end
      if (state == BIAS_WAIT) begin
        wait_cnt <= 1'b1;
        if (wait_cnt) bias_reg <= bias_in;
      end
      if (acc_we) begin
        acc[row_idx] <= lane_sum;
        row_cnt      <= row_cnt + CNT_W'(1);
      end
      if (ps_end) begin
        first_ps <= 1'b0;
        row_cnt  <= '0;
      end
      if (drain_go) drain_cnt <= '0;
      if (hs) begin
        acc[drain_idx] <= '0;
        drain_cnt      <= drain_cnt + CNT_W'(1);
      end
      if (drain_end) first_ps <= 1'b1;
      if (init_p && state != DRAIN) begin
        cfg_rows <= cfg_clamp;
        first_ps <= 1'b1;
        ovf_flag <= 1'b0;
        err_flag <= 1'b0;
      end
      // sticky sets take priority over a same-cycle clear
      if (drop || (init_p && state == DRAIN) || (start_p && state == DRAIN)) err_flag <= 1'b1;
      if (acc_we && |lane_ovf) ovf_flag <= 1'b1;
    end
  end

  assign out_valid = (state == DRAIN);
  assign out_last  = out_valid & drain_last;
  assign out_data  = out_valid ? acc[drain_idx] : '0;

endmodule

// File: tb/tb_oa_tile_accumulator.sv
// Randomized bench for oa_tile_accumulator against a row/lane arithmetic model with a drain scoreboard.
module tb_oa_tile_accumulator;
  localparam int SIZE = 16;
  localparam int DW   = 32;
  localparam int RW   = 32;
  localparam int RM   = 16;
  localparam longint MAXV = (longint'(1) <<< (DW - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (DW - 1));

  typedef logic [SIZE-1:0][DW-1:0] row_t;

  logic          clk = 1'b0;
  logic          rst_n, init_cfg, tile_calc_start, partial_sum_calc_over, tile_calc_over;
  logic          psum_valid, psum_ready, out_valid, out_ready, out_last, ovf_flag, err_flag;
  logic [RW-1:0] n_rows;
  row_t          bias_in, psum_in, out_data;

  int checks = 0;
  int errors = 0;

  longint m_acc [RM][SIZE];
  longint m_bias [SIZE];
  int     m_cfg, m_row;
  bit     m_first, m_ovf, m_err;
  row_t   exp_q [$];
  bit     mon_en = 1'b0;

  oa_tile_accumulator #(.SIZE(SIZE), .DATA_WIDTH(DW), .REG_WIDTH(RW), .ROWS_MAX(RM)) dut (
    .clk(clk), .rst_n(rst_n), .init_cfg(init_cfg), .n_rows(n_rows), .bias_in(bias_in),
    .tile_calc_start(tile_calc_start), .partial_sum_calc_over(partial_sum_calc_over),
    .tile_calc_over(tile_calc_over), .psum_valid(psum_valid), .psum_ready(psum_ready),
    .psum_in(psum_in), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .ovf_flag(ovf_flag), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [SIZE*DW-1:0] act, input logic [SIZE*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // ---- behavioural model ----
  function automatic longint sx(input logic [DW-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint sat(input longint s);
    if (s > MAXV) begin m_ovf = 1'b1; return MAXV; end
    if (s < MINV) begin m_ovf = 1'b1; return MINV; end
    return s;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < RM; r++) for (int l = 0; l < SIZE; l++) m_acc[r][l] = 0;
    m_first = 1'b1; m_cfg = 1; m_row = 0; m_ovf = 1'b0; m_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic m_beat(input row_t d);
    if (m_row < m_cfg) begin
      for (int l = 0; l < SIZE; l++)
        m_acc[m_row][l] = sat((m_first ? m_bias[l] : m_acc[m_row][l]) + sx(d[l]));
      m_row++;
    end else begin
      m_err = 1'b1;
    end
  endtask

  function automatic row_t fill(input logic [DW-1:0] v);
    row_t r;
    for (int l = 0; l < SIZE; l++) r[l] = v;
    return r;
  endfunction

  function automatic row_t rand_row();
    row_t r;
    for (int l = 0; l < SIZE; l++)
      r[l] = ($urandom_range(0, 5) == 0) ? DW'($urandom) : DW'($urandom_range(0, 2000)) - DW'(1000);
    return r;
  endfunction

  // ---- output scoreboard: every cycle ----
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("psum_ready_drain", psum_ready, 0);
        chk("out_data", out_data, exp_q[0]);
        chk("out_last", out_last, exp_q.size() == 1);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---- stimulus tasks (enter and leave at posedge+1) ----
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_init(input int n);
    init_cfg = 1'b1; n_rows = RW'(n);
    tick();
    init_cfg = 1'b0;
    m_cfg = (n == 0) ? 1 : ((n > RM) ? RM : n);
    m_first = 1'b1; m_ovf = 1'b0; m_err = 1'b0;
  endtask

  task automatic ps_begin();
    tile_calc_start = 1'b1;
    tick();
    tile_calc_start = 1'b0;
    @(negedge clk); chk("psum_ready_wait0", psum_ready, 0);
    tick();
    @(negedge clk); chk("psum_ready_wait1", psum_ready, 0);
    tick();
    for (int l = 0; l < SIZE; l++) m_bias[l] = sx(bias_in[l]);
    m_row = 0;
  endtask

  task automatic beat(input row_t d, input bit with_over);
    psum_valid = 1'b1; psum_in = d; partial_sum_calc_over = with_over;
    @(negedge clk); chk("psum_ready_accum", psum_ready, 1);
    tick();
    psum_valid = 1'b0; partial_sum_calc_over = 1'b0;
    m_beat(d);
    if (with_over) begin m_first = 1'b0; m_row = 0; end
  endtask

  task automatic ps_over();
    partial_sum_calc_over = 1'b1;
    tick();
    partial_sum_calc_over = 1'b0;
    m_first = 1'b0; m_row = 0;
  endtask

  task automatic drain(input int hold, input bit poke, input bit with_over);
    int   cnt;
    row_t r;
    tile_calc_over = 1'b1; partial_sum_calc_over = with_over; out_ready = 1'b0;
    tick();
    tile_calc_over = 1'b0; partial_sum_calc_over = 1'b0;
    if (with_over) begin m_first = 1'b0; m_row = 0; end
    for (int k = 0; k < m_cfg; k++) begin
      for (int l = 0; l < SIZE; l++) begin
        r[l] = m_acc[k][l][DW-1:0];
        m_acc[k][l] = 0;
      end
      exp_q.push_back(r);
    end
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 400) begin
      out_ready = (cnt < hold) ? 1'b0 : ($urandom_range(0, 3) != 0);
      tile_calc_start = poke && (cnt == 1);
      if (poke && cnt == 1) m_err = 1'b1;
      tick();
      cnt++;
    end
    tile_calc_start = 1'b0; out_ready = 1'b0; m_first = 1'b1;
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic chk_flags(input string nm);
    @(negedge clk);
    chk({nm, "_ovf"}, ovf_flag, m_ovf);
    chk({nm, "_err"}, err_flag, m_err);
    tick();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired act=running exp=finished");
    $fatal(1);
  end

  initial begin
    row_t r;
    int   n, nps, mode, nb;
    bit   last_ps, ow;

    rst_n = 1'b0; init_cfg = 1'b0; n_rows = '0; bias_in = '0; tile_calc_start = 1'b0;
    partial_sum_calc_over = 1'b0; tile_calc_over = 1'b0; psum_valid = 1'b0; psum_in = '0;
    out_ready = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_psum_ready", psum_ready, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_ovf", ovf_flag, 0);
    chk("rst_err", err_flag, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // 1: bias 5, rows 1 and 2 -> 6, 7
    do_init(2); bias_in = fill(32'd5);
    ps_begin(); beat(fill(32'd1), 1'b0); beat(fill(32'd2), 1'b0); ps_over();
    chk("t1_model_r0", m_acc[0][0], 6);
    chk("t1_model_r1", m_acc[1][SIZE-1], 7);
    drain(0, 1'b0, 1'b0);
    chk_flags("t1");

    // 2: three partial sums of 1 on bias 5 -> 8, bias applied once
    do_init(2); bias_in = fill(32'd5);
    for (int p = 0; p < 3; p++) begin
      ps_begin(); beat(fill(32'd1), 1'b0); beat(fill(32'd1), 1'b0); ps_over();
    end
    chk("t2_model", m_acc[1][3], 8);
    drain(0, 1'b0, 1'b0);
    chk_flags("t2");

    // 3: positive and negative saturation
    do_init(2);
    for (int l = 0; l < SIZE; l++) begin
      bias_in[l] = (l % 2 == 0) ? 32'h7FFF_FFF0 : 32'h8000_0010;
      r[l]       = (l % 2 == 0) ? 32'h0000_0020 : 32'hFFFF_FFE0;
    end
    ps_begin(); beat(r, 1'b1);
    chk("t3_model_pos", m_acc[0][0][DW-1:0], 32'h7FFF_FFFF);
    chk("t3_model_neg", m_acc[0][1][DW-1:0], 32'h8000_0000);
    chk("t3_model_ovf", m_ovf, 1);
    drain(0, 1'b0, 1'b0);
    chk_flags("t3");

    // 4: downstream stall for 5 cycles, plus a start pulse during drain
    do_init(3); bias_in = rand_row();
    ps_begin(); for (int b = 0; b < 3; b++) beat(rand_row(), 1'b0); ps_over();
    drain(5, 1'b1, 1'b0);
    chk("t4_model_err", m_err, 1);
    chk_flags("t4");

    // 5: one beat too many
    do_init(2); bias_in = fill(32'd0);
    ps_begin(); beat(fill(32'd11), 1'b0); beat(fill(32'd22), 1'b0); beat(fill(32'd33), 1'b0); ps_over();
    chk("t5_model_r1", m_acc[1][0], 22);
    drain(0, 1'b0, 1'b0);
    chk_flags("t5");

    // 6: reset mid-accumulation, then a clean tile
    do_init(1); bias_in = fill(32'd9);
    ps_begin(); beat(fill(32'd4), 1'b0); beat(fill(32'd4), 1'b0);
    rst_n = 1'b0; psum_valid = 1'b0;
    m_reset();
    @(negedge clk);
    chk("t6_rst_ovf", ovf_flag, 0);
    chk("t6_rst_err", err_flag, 0);
    tick();
    rst_n = 1'b1;
    tick();
    do_init(1); bias_in = fill(32'd0);
    ps_begin(); beat(fill(32'd3), 1'b0); ps_over();
    chk("t6_model", m_acc[0][0], 3);
    drain(0, 1'b0, 1'b0);
    chk_flags("t6");

    // randomized tiles
    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(0, 20);
      do_init(n);
      bias_in = rand_row();
      nps  = $urandom_range(1, 3);
      mode = $urandom_range(0, 2);
      for (int p = 0; p < nps; p++) begin
        last_ps = (p == nps - 1);
        ps_begin();
        nb = ($urandom_range(0, 3) == 0) ? m_cfg + 1 : int'($urandom_range(0, m_cfg));
        ow = (!last_ps || mode == 0) && (nb > 0) && ($urandom_range(0, 1) == 1);
        for (int b = 0; b < nb; b++) begin
          if ($urandom_range(0, 3) == 0) tick();
          beat(rand_row(), ow && (b == nb - 1));
        end
        if ((!last_ps || mode == 0) && !ow) ps_over();
      end
      drain($urandom_range(0, 3), 1'b0, mode == 2);
      chk_flags("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
